// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: shared types and helpers for the queued command sequencer.
//   opcode_e  - 2-bit command opcode carried in the top bits of a command word
//   state_e   - sequencer FSM states
//   cyc_sel() - picks the short simulation cycle count or the nominal one
//   max2()    - integer maximum, used to size the shared turn/buzz timer
package cmd_seq_pkg;

    typedef enum logic [1:0] {
        OP_STOP   = 2'b00,
        OP_FOLLOW = 2'b01,
        OP_TURN   = 2'b10,
        OP_BUZZ   = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOLLOW,
        ST_TURN,
        ST_BUZZ,
        ST_BUMP
    } state_e;

    localparam int FAST_CYC = 16;

    function automatic int cyc_sel(input int fast_sim, input int nominal);
        return (fast_sim != 0) ? FAST_CYC : nominal;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cmd_seq_bmp_debounce.sv
// bmp_debounce: one bumper channel.
//   clk, rst : clock, asynchronous active-high reset
//   bmp_n    : raw active-low bumper input (asynchronous to clk)
//   pressed  : debounced, active-high contact indication
// The raw input passes through a 2-flop synchroniser; the debounced output
// only follows the synchronised level once it has held a new value for
// DB_CYC consecutive clocks (the synchroniser's second stage supplies the
// first of those clocks, so the counter itself needs DB_CYC-1 more).
module bmp_debounce #(
    parameter int DB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic bmp_n,
    output logic pressed
);

    localparam int CNT_W = $clog2(DB_CYC) + 1;

    logic             sync1_reg;
    logic             sync2_reg;
    logic             pressed_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            pressed_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync1_reg <= bmp_n;
            sync2_reg <= sync1_reg;
            if ((!sync2_reg) == pressed_reg) begin
                // Input agrees with the output: any partial run is discarded.
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DB_CYC - 2)) begin
                pressed_reg <= !sync2_reg;
                cnt_reg     <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign pressed = pressed_reg;

endmodule

// File: rtl/cmd_seq.sv
// cmd_seq: queued command sequencer for the line-following robot.
//   clk, rst     : clock, asynchronous active-high reset
//   cmd, cmd_rdy : command word and valid from the UART wrapper
//   clr_cmd_rdy  : combinational acknowledge; word is taken on that edge
//   BMP_n        : raw active-low bumper inputs, one per channel
//   line_present : line detected by the IR interface
//   go           : forward ramp enable
//   err_opn_lp   : signed error override (0 = no override)
//   buzz         : buzzer enable
//   busy         : FSM not idle or commands still queued
//   bmp_evt      : one-cycle pulse on entering BUMP
// Commands are queued in a DEPTH-entry FIFO and executed one at a time by
// a Moore FSM whose outputs are registered alongside the state.
module cmd_seq
    import cmd_seq_pkg::*;
#(
    parameter int                      CMD_W    = 16,
    parameter int                      DEPTH    = 4,
    parameter int                      N_BMP    = 2,
    parameter int                      ERR_W    = 12,
    parameter logic signed [ERR_W-1:0] TURN_MAG = 12'sh340,
    parameter int                      TURN_CYC = 2**22,
    parameter int                      DB_CYC   = 2**20,
    parameter int                      BUZZ_CYC = 2**23,
    parameter int                      FAST_SIM = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CMD_W-1:0]        cmd,
    input  logic                    cmd_rdy,
    output logic                    clr_cmd_rdy,
    input  logic [N_BMP-1:0]        BMP_n,
    input  logic                    line_present,
    output logic                    go,
    output logic signed [ERR_W-1:0] err_opn_lp,
    output logic                    buzz,
    output logic                    busy,
    output logic                    bmp_evt
);

    localparam int TURN_C = cyc_sel(FAST_SIM, TURN_CYC);
    localparam int BUZZ_C = cyc_sel(FAST_SIM, BUZZ_CYC);
    localparam int DB_C   = cyc_sel(FAST_SIM, DB_CYC);
    localparam int TMR_W  = $clog2(max2(TURN_C, BUZZ_C)) + 1;
    localparam int SEG_W  = CMD_W - 2;
    localparam int AW     = $clog2(DEPTH);

    // ---------------- bumper debouncers ----------------
    logic [N_BMP-1:0] bmp_db;

    generate
        for (genvar gi = 0; gi < N_BMP; gi++) begin : g_bmp
            bmp_debounce #(.DB_CYC(DB_C)) u_db (
                .clk     (clk),
                .rst     (rst),
                .bmp_n   (BMP_n[gi]),
                .pressed (bmp_db[gi])
            );
        end
    endgenerate

    logic any_bump;
    assign any_bump = |bmp_db;

    // ---------------- command FIFO ----------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CMD_W-1:0] fifo_mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CMD_W-1:0] head;
    opcode_e          head_op;
    logic [SEG_W-1:0] head_arg;

    state_e           state_reg;
    state_e           state_next;

    logic pop;
    logic push;
    logic flush;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head       = fifo_mem[rd_ptr_reg[AW-1:0]];
    assign head_op    = opcode_e'(head[CMD_W-1:CMD_W-2]);
    assign head_arg   = head[SEG_W-1:0];

    assign pop   = (state_reg == ST_IDLE) && !fifo_empty;
    // Entering BUMP discards the queue and any word arriving that same cycle.
    assign flush = ((state_reg == ST_FOLLOW) || (state_reg == ST_TURN)) && any_bump;
    // In BUMP words are acknowledged but dropped so the wrapper never stalls.
    assign clr_cmd_rdy = cmd_rdy && (!fifo_full || pop || (state_reg == ST_BUMP));
    assign push = cmd_rdy && (!fifo_full || pop) && (state_reg != ST_BUMP) && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= cmd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            rd_ptr_reg <= wr_ptr_reg;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // ---------------- sequencer FSM ----------------
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic [SEG_W-1:0] seg_reg, seg_next;
    logic             right_reg, right_next;
    logic             line_prev_reg;
    logic             line_fall;
    logic             go_reg, buzz_reg, bmp_evt_reg;
    logic signed [ERR_W-1:0] err_reg;

    assign line_fall = line_prev_reg && !line_present;

    always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg;
        seg_next   = seg_reg;
        right_next = right_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    unique case (head_op)
                        OP_STOP: state_next = ST_IDLE;
                        OP_FOLLOW: begin
                            state_next = ST_FOLLOW;
                            seg_next   = (head_arg == '0) ? SEG_W'(1) : head_arg;
                        end
                        OP_TURN: begin
                            state_next = ST_TURN;
                            tmr_next   = TMR_W'(TURN_C - 1);
                            right_next = head_arg[0];
                        end
                        OP_BUZZ: begin
                            state_next = ST_BUZZ;
                            tmr_next   = TMR_W'(BUZZ_C - 1);
                        end
                    endcase
                end
            end
            ST_FOLLOW: begin
                if (any_bump) begin
                    state_next = ST_BUMP;
                end else if (line_fall) begin
                    if (seg_reg <= SEG_W'(1)) state_next = ST_IDLE;
                    else                      seg_next   = seg_reg - 1'b1;
                end
            end
            ST_TURN: begin
                if (any_bump)             state_next = ST_BUMP;
                else if (tmr_reg == '0)   state_next = ST_IDLE;
                else                      tmr_next   = tmr_reg - 1'b1;
            end
            ST_BUZZ: begin
                if (tmr_reg == '0) state_next = ST_IDLE;
                else               tmr_next   = tmr_reg - 1'b1;
            end
            ST_BUMP: begin
                if (!any_bump) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered with it, so
    // each output register always matches the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            tmr_reg       <= '0;
            seg_reg       <= '0;
            right_reg     <= 1'b0;
            line_prev_reg <= 1'b0;
            go_reg        <= 1'b0;
            buzz_reg      <= 1'b0;
            err_reg       <= '0;
            bmp_evt_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tmr_reg       <= tmr_next;
            seg_reg       <= seg_next;
            right_reg     <= right_next;
            line_prev_reg <= line_present;
            go_reg        <= (state_next == ST_FOLLOW) || (state_next == ST_TURN);
            buzz_reg      <= (state_next == ST_BUZZ) || (state_next == ST_BUMP);
            err_reg       <= (state_next == ST_TURN) ? (right_next ? -TURN_MAG : TURN_MAG) : '0;
            bmp_evt_reg   <= (state_next == ST_BUMP) && (state_reg != ST_BUMP);
        end
    end

    assign go         = go_reg;
    assign buzz       = buzz_reg;
    assign err_opn_lp = err_reg;
    assign bmp_evt    = bmp_evt_reg;
    assign busy       = (state_reg != ST_IDLE) || !fifo_empty;

endmodule
